// File: rtl/atctlc2axi500_burst_route.sv
// Response router for the N-to-1 burst arbiter: an in-order FIFO of one-hot grants
// steers each last-terminated response burst back to the requester that owned it.

module atctlc2axi500_burst_route_lane (
  input  logic i_head,
  input  logic i_busy,
  input  logic i_resp_valid,
  input  logic i_ready,
  output logic o_valid,
  output logic o_rdy_term
);
  assign o_valid    = i_busy & i_head & i_resp_valid;
  assign o_rdy_term = i_busy & i_head & i_ready;
endmodule

module atctlc2axi500_burst_route #(
  parameter int N     = 2,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [N-1:0]     push_grants,
  output logic             push_ready,
  input  logic             resp_valid,
  input  logic             resp_last,
  output logic             resp_ready,
  output logic [N-1:0]     valids,
  input  logic [N-1:0]     readys,
  output logic [PTR_W:0]   count,
  output logic             err
);
  localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][N-1:0] r_mem;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_count;
  logic                    r_err;

  logic [N-1:0] w_head;
  logic [N-1:0] w_valids;
  logic [N-1:0] w_rdy_terms;
  logic         w_busy;
  logic         w_onehot;
  logic         w_accept;
  logic         w_fire;
  logic         w_pop;

  assign w_busy   = (r_count != '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_onehot = (push_grants != '0) && ((push_grants & (push_grants - N'(1))) == '0);

  // push_ready is from the pre-pop count: a full FIFO never refills in the same cycle
  assign push_ready = (r_count < L_DEPTH);
  assign w_accept   = push & push_ready & w_onehot;

  for (genvar g = 0; g < N; g++) begin : g_lane
    atctlc2axi500_burst_route_lane u_lane (
      .i_head       (w_head[g]),
      .i_busy       (w_busy),
      .i_resp_valid (resp_valid),
      .i_ready      (readys[g]),
      .o_valid      (w_valids[g]),
      .o_rdy_term   (w_rdy_terms[g])
    );
  end

  assign valids     = w_valids;
  assign resp_ready = |w_rdy_terms;
  assign w_fire     = resp_valid & resp_ready;
  assign w_pop      = w_fire & resp_last;
  assign count      = r_count;
  assign err        = r_err;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= push & ~w_onehot;
      if (w_accept) begin
        r_mem[r_wr_ptr] <= push_grants;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_valids_onehot0: assert property (@(posedge clk) disable iff (!resetn) $onehot0(valids));
  a_count_bound:    assert property (@(posedge clk) disable iff (!resetn) r_count <= L_DEPTH);
  a_no_empty_pop:   assert property (@(posedge clk) disable iff (!resetn) !(w_pop && !w_busy));
`endif

endmodule

// File: tb/tb_atctlc2axi500_burst_route.sv
// Bench for atctlc2axi500_burst_route: vector table, directed corner sequences and
// random traffic checked against a queue-based model of the grant FIFO.

module tb_atctlc2axi500_burst_route;
  logic       clk = 1'b0;
  logic       resetn;
  logic       push;
  logic [1:0] push_grants;
  logic       push_ready;
  logic       resp_valid;
  logic       resp_last;
  logic       resp_ready;
  logic [1:0] valids;
  logic [1:0] readys;
  logic [2:0] count;
  logic       err;

  int total = 0;
  int bad   = 0;

  // reference model: outstanding owners in order, plus pending error flag
  int q[$];
  int m_err = 0;

  always #5 clk = ~clk;

  atctlc2axi500_burst_route #(.N(2), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn), .push(push), .push_grants(push_grants),
    .push_ready(push_ready), .resp_valid(resp_valid), .resp_last(resp_last),
    .resp_ready(resp_ready), .valids(valids), .readys(readys),
    .count(count), .err(err)
  );

  typedef struct {
    int push, g, rv, last, rdy;
    int e_pr, e_rr, e_val, e_cnt, e_err;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_onehot(input int g);
    return ($countones(g[1:0]) == 1) ? 1 : 0;
  endfunction

  // one clock: drive at negedge, compare against model before the edge, then advance model
  task automatic cyc(input int p, input int g, input int rv, input int last, input int rdy);
    int e_pr, e_rr, e_val, head, acc, pop;
    push = p[0]; push_grants = g[1:0]; resp_valid = rv[0]; resp_last = last[0]; readys = rdy[1:0];
    #2;
    head  = (q.size() != 0) ? q[0] : 0;
    e_pr  = (q.size() < 4) ? 1 : 0;
    e_val = rv ? head : 0;
    e_rr  = ((head & rdy) != 0) ? 1 : 0;
    chk("push_ready", int'(push_ready), e_pr);
    chk("resp_ready", int'(resp_ready), e_rr);
    chk("valids",     int'(valids),     e_val);
    chk("count",      int'(count),      q.size());
    chk("err",        int'(err),        m_err);
    pop   = rv & e_rr & last;
    acc   = p & e_pr & m_onehot(g);
    m_err = (p != 0 && m_onehot(g) == 0) ? 1 : 0;
    if (pop != 0) void'(q.pop_front());
    if (acc != 0) q.push_back(g & 3);
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0; push = 0; push_grants = 0; resp_valid = 0; resp_last = 0; readys = 0;
    q.delete(); m_err = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  vec_t vt[$];

  initial begin
    // hand-derived expectations: two bursts routed in order, bad pushes, no-bypass case
    vt.push_back('{1,1,0,0,0, 1,0,0,0,0});
    vt.push_back('{1,2,0,0,0, 1,0,0,1,0});
    vt.push_back('{0,0,1,0,3, 1,1,1,2,0});
    vt.push_back('{0,0,1,0,3, 1,1,1,2,0});
    vt.push_back('{0,0,1,1,3, 1,1,1,2,0});
    vt.push_back('{0,0,1,0,3, 1,1,2,1,0});
    vt.push_back('{0,0,1,1,3, 1,1,2,1,0});
    vt.push_back('{0,0,1,0,3, 1,0,0,0,0});
    vt.push_back('{1,3,0,0,0, 1,0,0,0,0});
    vt.push_back('{1,0,0,0,0, 1,0,0,0,1});
    vt.push_back('{0,0,0,0,0, 1,0,0,0,1});
    vt.push_back('{0,0,0,0,0, 1,0,0,0,0});
    vt.push_back('{1,2,1,1,2, 1,0,0,0,0});
    vt.push_back('{0,0,1,1,2, 1,1,2,1,0});
    vt.push_back('{0,0,0,0,0, 1,0,0,0,0});

    do_reset();
    chk("rst_push_ready", int'(push_ready), 1);
    chk("rst_resp_ready", int'(resp_ready), 0);
    chk("rst_valids",     int'(valids),     0);
    chk("rst_count",      int'(count),      0);
    chk("rst_err",        int'(err),        0);

    foreach (vt[i]) begin
      push = vt[i].push[0]; push_grants = vt[i].g[1:0]; resp_valid = vt[i].rv[0];
      resp_last = vt[i].last[0]; readys = vt[i].rdy[1:0];
      #2;
      chk($sformatf("vec%0d_push_ready", i), int'(push_ready), vt[i].e_pr);
      chk($sformatf("vec%0d_resp_ready", i), int'(resp_ready), vt[i].e_rr);
      chk($sformatf("vec%0d_valids", i),     int'(valids),     vt[i].e_val);
      chk($sformatf("vec%0d_count", i),      int'(count),      vt[i].e_cnt);
      chk($sformatf("vec%0d_err", i),        int'(err),        vt[i].e_err);
      @(negedge clk);
    end

    // fill to DEPTH, refused push alongside a pop, then wrap the pointers
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, (i % 2) ? 2 : 1, 0, 0, 0);
    chk("full_push_ready", int'(push_ready), 0);
    cyc(1, 2, 1, 1, 3);
    chk("after_full_pop_count", int'(count), 3);
    chk("after_full_pop_ready", int'(push_ready), 1);
    for (int i = 0; i < 6; i++) cyc(1, (i % 3 == 0) ? 2 : 1, 1, 1, 3);
    chk("wrap_count", int'(count), 3);

    // head stalls with readys low; non-head ready toggles must not matter
    do_reset();
    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, (i % 2) ? 2 : 0);
    chk("stall_count", int'(count), 1);
    cyc(0, 0, 1, 1, 1);
    chk("stall_release_count", int'(count), 0);

    // asynchronous reset mid-burst with three outstanding
    do_reset();
    cyc(1, 2, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 2, 1, 0, 3);
    push = 0; resp_valid = 1; resp_last = 0; readys = 3;
    #2;
    chk("pre_rst_count", int'(count), 3);
    resetn = 1'b0;
    #1;
    chk("arst_count",      int'(count),      0);
    chk("arst_valids",     int'(valids),     0);
    chk("arst_resp_ready", int'(resp_ready), 0);
    chk("arst_push_ready", int'(push_ready), 1);
    q.delete(); m_err = 0;
    @(negedge clk);
    resetn = 1'b1; resp_valid = 0;
    @(negedge clk);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 1);
    chk("post_rst_count", int'(count), 0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 2) != 0) ? 1 : 0, $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule
